sample_framer: RTL
==================

Name: sample_framer

Overview:
- Upstream stage of the min/max range tracker. Accepts raw 10-bit samples over a valid/ready handshake and buffers them in a small FIFO.
- Emits framed samples: go on the first sample of a frame, finish on the last, then one idle gap cycle. This matches the tracker's waiting/starting/ending sequence.
- Outputs are registered and feed the tracker's data/go/finish inputs directly.

Parameters:
- DATA_W, 10, sample width.
- FIFO_DEPTH, 4, input FIFO entries (power of two, >=2).
- LEN_W, 4, width of frame_len.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high
- in_data  input  DATA_W  raw sample
- in_valid  input  1  sample present
- in_ready  output  1  FIFO can accept; equals !full
- enable  input  1  permits new frame starts
- frame_len  input  LEN_W  samples per frame; latched at frame start
- flush  input  1  synchronous; terminates the current frame and clears the FIFO
- out_data  output  DATA_W  framed sample, registered
- out_valid  output  1  out_data is a real sample this cycle
- out_go  output  1  first sample of frame
- out_finish  output  1  last sample of frame
- frame_count  output  8  completed frames, wraps 255->0

Behaviour:
- Reset values: all outputs 0, FIFO empty, FSM IDLE, frame_count 0. in_ready becomes 1 in the first cycle after reset deasserts.
- Push: occurs when in_valid && in_ready. When full, in_ready=0, so a push is never accepted while full, even if a pop happens in the same cycle.
- Pop: only in FRAME states with FIFO non-empty. Pop and push in the same cycle are allowed when not full.
- Latency: a popped sample appears on out_data the next cycle. Minimum push-to-out latency is 2 cycles from IDLE.
- Length rule: effective length L = max(frame_len, 2). Values 0 and 1 clamp to 2, so go and finish never coincide.
- Remaining-count register: LEN_W bits, loaded with L-1 on the first pop.
- FSM states: IDLE, FIRST, BODY, GAP.
- IDLE: if enable && !empty && !flush, pop and go to BODY; the registered output is valid=1, go=1. Otherwise outputs are 0.
  - The FIRST label is the one-cycle registered view. An implementation may merge it into IDLE->BODY; the externally visible behaviour is as specified.
- BODY, FIFO non-empty: pop and decrement remaining. When the popped sample is the last (remaining was 1), output finish=1 and go to GAP.
- BODY, FIFO empty: bubble cycle. out_valid=0, go=finish=0, out_data holds its previous value. A repeated value cannot change min/max, so the tracker is unaffected.
- GAP: exactly one cycle with all strobes 0 and out_data held. frame_count increments here. Then go to IDLE.
- A new frame's go appears at the earliest 2 cycles after the previous finish.
- flush in IDLE or GAP: FIFO cleared, state unchanged (GAP still completes).
- flush in BODY: FIFO cleared. Next cycle outputs finish=1, valid=1 with out_data held, then GAP. frame_count increments.
- flush while a pop is pending in the same cycle: flush wins, no pop.
- enable deasserted mid-frame: has no effect until the frame completes.
- frame_len changes mid-frame: ignored, since the length is latched.
- Asynchronous reset mid-frame: everything returns to reset values immediately and no finish is emitted. The downstream tracker shares the same reset.
- Invariant: out_go and out_finish are never both 1.
- Invariant: out_go/out_finish imply out_valid.

Decomposition:
- Shared package framer_pkg holds:
  - typedef enum framer_state_t {IDLE, FIRST, BODY, GAP}
  - localparam MIN_FRAME_LEN = 2
  - the DATA_W default of 10, shared with the tracker
- One sub-module, sample_fifo:
  - parameterised DATA_W/FIFO_DEPTH
  - push/pop/flush inputs
  - full/empty outputs and registered read-ahead output
  - pointer width clog2(DEPTH)+1 for full/empty disambiguation
- The framer FSM, length counter and output registers live in sample_framer.

Test Plan:
- Basic frame: enable=1, frame_len=4, push 10,3,7,5 on consecutive cycles. Expected out: 10(go), 3, 7, 5(finish), then GAP with valid=0, then frame_count=1.
- Starvation: frame_len=3, push 20, wait 3 cycles, push 40, push 30. Expected out: 20(go), three bubbles holding 20 with valid=0, 40, 30(finish).
- Backpressure: enable=0, push 5 samples. Expected: in_ready drops after 4 accepts and the 5th is held. Raising enable drains the FIFO, and in_ready returns to 1 the cycle after the first pop.
- Length clamp: frame_len=1, push 9,8. Expected out: 9(go), 8(finish); go and finish never both asserted.
- Flush mid-frame: frame_len=8, push 1,2,3, assert flush after 2 is output. Expected: next cycle finish=1 with data 2, then GAP, FIFO empty, frame_count+1.
- Reset and wrap: 256 frames of length 2 gives frame_count back to 0. Async reset mid-BODY clears all outputs the same cycle, and in_ready=1 after release.

Source files
------------

// File: rtl/framer_pkg.sv
// Shared types and constants for the sample framer and the downstream
// min/max range tracker.
package framer_pkg;

  // Sample width shared by the framer and the tracker.
  localparam int DEFAULT_DATA_W = 10;

  // Shortest frame emitted, so that go and finish never land on one sample.
  localparam int MIN_FRAME_LEN = 2;

  // FIRST is the registered view of the frame's first sample; the framer
  // folds it into the IDLE->BODY transition.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    BODY  = 2'd2,
    GAP   = 2'd3
  } framer_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Small input FIFO for the sample framer. The head entry is always visible
// on rd_data (read-ahead), so a pop and its data are used in the same cycle.
// Pointers carry one extra bit so that full and empty can be told apart.
module sample_fifo
  import framer_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W:0] PTR_ZERO = {(ADDR_W + 1){1'b0}};
  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0]   wr_ptr_r;
  logic [ADDR_W:0]   rd_ptr_r;
  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full  = (wr_ptr_r[ADDR_W] != rd_ptr_r[ADDR_W]) &&
                 (wr_ptr_r[ADDR_W-1:0] == rd_ptr_r[ADDR_W-1:0]);
  assign empty = (wr_ptr_r == rd_ptr_r);

  // Flush beats both push and pop in the same cycle.
  assign push_ok_s = push && !full && !flush;
  assign pop_ok_s  = pop && !empty && !flush;
  assign rd_data   = mem_r[rd_ptr_r[ADDR_W-1:0]];

  // Pointer update; flush empties the FIFO by returning both pointers home.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else if (flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Storage write; contents need no reset because empty gates every read.
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[ADDR_W-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/sample_framer.sv
// Sample framer: buffers raw samples and emits them as frames with go on the
// first sample, finish on the last and a single idle gap cycle afterwards.
// All outputs toward the range tracker are registered.
module sample_framer
  import framer_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              enable,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              flush,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_go,
  output logic              out_finish,
  output logic [7:0]        frame_count
);

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W - 1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_FRAME_LEN);

  framer_state_t     state_r;
  framer_state_t     state_next_s;
  logic [LEN_W-1:0]  rem_r;
  logic [DATA_W-1:0] out_data_r;
  logic              out_valid_r;
  logic              out_go_r;
  logic              out_finish_r;
  logic [7:0]        frame_count_r;
  logic              ready_en_r;

  logic [DATA_W-1:0] fifo_data_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              push_s;
  logic              pop_s;
  logic              load_s;
  logic              dec_s;
  logic              take_s;
  logic              valid_s;
  logic              go_s;
  logic              finish_s;
  logic              count_s;

  // Effective frame length: short requests are raised to the minimum.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    if (len < LEN_MIN) begin
      eff_len = LEN_MIN;
    end else begin
      eff_len = len;
    end
  endfunction

  assign in_ready = ready_en_r && !fifo_full_s;
  assign push_s   = in_valid && in_ready;

  sample_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push_s),
    .pop     (pop_s),
    .flush   (flush),
    .wr_data (in_data),
    .rd_data (fifo_data_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Input acceptance opens on the first clock after reset is released.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_en_r <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
    end
  end

  // Framer state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and next-output decode; every strobe defaults low.
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    load_s       = 1'b0;
    dec_s        = 1'b0;
    take_s       = 1'b0;
    valid_s      = 1'b0;
    go_s         = 1'b0;
    finish_s     = 1'b0;
    count_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable && !fifo_empty_s && !flush) begin
          pop_s        = 1'b1;
          load_s       = 1'b1;
          take_s       = 1'b1;
          valid_s      = 1'b1;
          go_s         = 1'b1;
          state_next_s = BODY;
        end else begin
          state_next_s = IDLE;
        end
      end
      BODY: begin
        if (flush) begin
          // Close the frame on the sample already shown; data is held.
          valid_s      = 1'b1;
          finish_s     = 1'b1;
          state_next_s = GAP;
        end else if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          dec_s   = 1'b1;
          take_s  = 1'b1;
          valid_s = 1'b1;
          if (rem_r == LEN_ONE) begin
            finish_s     = 1'b1;
            state_next_s = GAP;
          end else begin
            state_next_s = BODY;
          end
        end else begin
          // Starved: bubble with data held, harmless to min/max tracking.
          state_next_s = BODY;
        end
      end
      GAP: begin
        count_s      = 1'b1;
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Output registers, remaining-sample counter and completed-frame counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_data_r    <= {DATA_W{1'b0}};
      out_valid_r   <= 1'b0;
      out_go_r      <= 1'b0;
      out_finish_r  <= 1'b0;
      rem_r         <= {LEN_W{1'b0}};
      frame_count_r <= 8'd0;
    end else begin
      out_valid_r  <= valid_s;
      out_go_r     <= go_s;
      out_finish_r <= finish_s;
      if (take_s) begin
        out_data_r <= fifo_data_s;
      end
      if (load_s) begin
        rem_r <= eff_len(frame_len) - LEN_ONE;
      end else if (dec_s) begin
        rem_r <= rem_r - LEN_ONE;
      end
      if (count_s) begin
        frame_count_r <= frame_count_r + 8'd1;
      end
    end
  end

  assign out_data    = out_data_r;
  assign out_valid   = out_valid_r;
  assign out_go      = out_go_r;
  assign out_finish  = out_finish_r;
  assign frame_count = frame_count_r;

endmodule
